// File: rtl/shift_pkg.sv
// Shared types and default widths for the shift sweep generator.
package shift_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sweep_state_t;

  localparam int SHIFT_WIDTH = 8;
  localparam int SHIFT_CNT_W = 8;

endpackage

// File: rtl/shift_sweep_gen.sv
// Command-driven (data, shift) beat source feeding a barrel shifter.
// One command launches a sweep of cmd_count beats; shift advances by the
// latched step on every accepted beat and wraps naturally at WIDTH.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a command; cmd_ready high, no beat presented
// RUN   | sweep in progress; beat presented, commands ignored
module shift_sweep_gen
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH,
  parameter int SHW   = $clog2(WIDTH),
  parameter int CNT_W = SHIFT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [SHW-1:0]   cmd_start,
  input  logic [SHW-1:0]   cmd_step,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_shift,
  output logic             out_last,
  output logic             busy
);

  sweep_state_t     state;
  logic [SHW-1:0]   step_q;
  logic [CNT_W-1:0] remaining;

  // Status and last-beat flag decode straight from state and counter so the
  // next command is visible the cycle after the final beat is taken.
  assign cmd_ready = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_last  = out_valid && (remaining == CNT_W'(1));

  // Sweep sequencer: latch a command, then step shift and count down beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_shift <= '0;
      step_q    <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A zero-count command is consumed here without producing a beat.
          if (cmd_valid && (cmd_count != '0)) begin
            out_data  <= cmd_data;
            out_shift <= cmd_start;
            step_q    <= cmd_step;
            remaining <= cmd_count;
            out_valid <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (out_valid && out_ready) begin
            out_shift <= out_shift + step_q;
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sweep_gen.sv
// Randomized and directed bench for shift_sweep_gen against a queue model:
// each accepted command expands into its full list of expected beats.
module tb_shift_sweep_gen;

  localparam int WIDTH = 8;
  localparam int SHW   = 3;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_data;
  logic [SHW-1:0]   cmd_start;
  logic [SHW-1:0]   cmd_step;
  logic [CNT_W-1:0] cmd_count;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [SHW-1:0]   out_shift;
  logic             out_last;
  logic             busy;

  shift_sweep_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_start (cmd_start),
    .cmd_step  (cmd_step),
    .cmd_count (cmd_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_shift (out_shift),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   shift;
    logic             last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    n_beats  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called with inputs set for the coming edge; checks outputs, updates the
  // model for what that edge will do, then advances to 1 ns past the edge.
  task automatic cycle();
    beat_t b;
    bit    idle;
    idle = (exp_q.size() == 0);
    chk("cmd_ready", 32'(cmd_ready), 32'(idle));
    chk("busy", 32'(busy), 32'(!idle));
    chk("out_valid", 32'(out_valid), 32'(!idle));
    if (!idle) begin
      chk("out_data", 32'(out_data), 32'(exp_q[0].data));
      chk("out_shift", 32'(out_shift), 32'(exp_q[0].shift));
      chk("out_last", 32'(out_last), 32'(exp_q[0].last));
      if (out_ready) begin
        void'(exp_q.pop_front());
        n_beats++;
      end
    end else begin
      chk("out_last_idle", 32'(out_last), 32'd0);
      if (cmd_valid) begin
        for (int i = 0; i < int'(cmd_count); i++) begin
          b.data  = cmd_data;
          b.shift = SHW'((int'(cmd_start) + i * int'(cmd_step)) % WIDTH);
          b.last  = (i == int'(cmd_count) - 1);
          exp_q.push_back(b);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [WIDTH-1:0] d, input int st, input int sp, input int cnt);
    cmd_data  = d;
    cmd_start = SHW'(st);
    cmd_step  = SHW'(sp);
    cmd_count = CNT_W'(cnt);
  endtask

  // Run until the model has drained, bounded by a cycle budget.
  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int hs_before;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    out_ready = 1'b0;
    set_cmd('0, 0, 0, 0);
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_shift", 32'(out_shift), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    #9 rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic sweep with wrap past 7 and a trailing idle cycle.
    set_cmd(8'b0101_0110, 0, 1, 10);
    cmd_valid = 1'b1;
    out_ready = 1'b1;
    cycle();
    cmd_valid = 1'b0;
    drain(20);
    cycle();

    // Step of 3 from 6: 6,1,4,7.
    set_cmd(8'hA3, 6, 3, 4);
    cmd_valid = 1'b1;
    cycle();
    cmd_valid = 1'b0;
    drain(10);
    cycle();

    // Zero-count command: consumed, no beat, never busy.
    set_cmd(8'hFF, 2, 1, 0);
    cmd_valid = 1'b1;
    cycle();
    cmd_valid = 1'b0;
    repeat (3) cycle();

    // Step of zero repeats one shift.
    set_cmd(8'h3C, 5, 0, 3);
    cmd_valid = 1'b1;
    cycle();
    cmd_valid = 1'b0;
    drain(10);

    // Random stalls during a count=5 sweep.
    hs_before = n_beats;
    set_cmd(8'h81, 2, 5, 5);
    cmd_valid = 1'b1;
    out_ready = 1'b0;
    cycle();
    cmd_valid = 1'b0;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      out_ready = ($urandom_range(0, 2) == 0);
      cycle();
    end
    chk("stall_handshakes", 32'(n_beats - hs_before), 32'd5);
    drain(5);
    out_ready = 1'b1;

    // Asynchronous reset in the middle of beat 3 of a count=8 sweep.
    set_cmd(8'h11, 0, 1, 8);
    cmd_valid = 1'b1;
    cycle();
    cmd_valid = 1'b0;
    cycle();
    cycle();
    chk("pre_rst_shift", 32'(out_shift), 32'd2);
    #3 rst = 1'b1;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("async_out_last", 32'(out_last), 32'd0);
    exp_q.delete();
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    cycle();
    set_cmd(8'hC7, 5, 2, 3);
    cmd_valid = 1'b1;
    cycle();
    cmd_valid = 1'b0;
    drain(10);

    // Back-to-back with cmd_valid held; the second command is taken only
    // once the first has drained, leaving one bubble.
    set_cmd(8'h5A, 1, 1, 3);
    cmd_valid = 1'b1;
    cycle();
    set_cmd(8'hE4, 7, 2, 4);
    for (int i = 0; i < 20 && !(exp_q.size() == 0 && cmd_ready == 1'b0); i++) begin
      cycle();
    end
    cmd_valid = 1'b0;
    drain(10);

    // Maximum-length sweep.
    set_cmd(8'h99, 3, 7, 255);
    cmd_valid = 1'b1;
    cycle();
    cmd_valid = 1'b0;
    drain(300);

    // Random commands and back-pressure.
    for (int i = 0; i < 600; i++) begin
      cmd_valid = $urandom_range(0, 1);
      set_cmd(WIDTH'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12)));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    cmd_valid = 1'b0;
    out_ready = 1'b1;
    drain(20);
    cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
